// File: rtl/serial_logic_pkg.sv
// serial_logic_pkg: opcode and FSM state types shared by the serial logic unit.
package serial_logic_pkg;
    localparam int OP_W = 3;
    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_RSVD = 3'd7
    } op_e;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/serial_logic_unit_bit_gate.sv
// bit_gate: combinational 1-bit gate selector; the reserved opcode yields 0.
module bit_gate
    import serial_logic_pkg::*;
(
    input  op_e  op,
    input  logic x,
    input  logic y,
    output logic z
);
    always_comb begin
        z = 1'b0;
        case (op)
            OP_AND:  z = x & y;
            OP_OR:   z = x | y;
            OP_NOT:  z = ~x;
            OP_NAND: z = ~(x & y);
            OP_NOR:  z = ~(x | y);
            OP_XOR:  z = x ^ y;
            OP_XNOR: z = ~(x ^ y);
            default: z = 1'b0;
        endcase
    end
endmodule

// File: rtl/serial_logic_unit.sv
// serial_logic_unit: bit-serial logic unit, one result bit per clock, LSB first.
// Optional parity output enabled by SERIAL_LOGIC_PARITY_EN.
module serial_logic_unit
    import serial_logic_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_LOGIC_PARITY_EN
    output logic             parity,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);
    state_e           state, state_nx;
    op_e              op_q;
    logic [WIDTH-1:0] a_sh, b_sh, res_nx;
    logic [CNT_W-1:0] cnt;
    logic             bit_z, last, accept;

    bit_gate u_gate (.op(op_q), .x(a_sh[0]), .y(b_sh[0]), .z(bit_z));

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign last      = cnt == CNT_W'(WIDTH - 1);
    assign res_nx    = {bit_z, result[WIDTH-1:1]};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? SHIFT : IDLE;
            SHIFT:   state_nx = last ? DONE : SHIFT;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= OP_AND;
            a_sh   <= '0;
            b_sh   <= '0;
            result <= '0;
            cnt    <= '0;
            zero   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_sh   <= a;
                b_sh   <= b;
                op_q   <= op_e'(op);
                result <= '0;
                cnt    <= '0;
            end else if (state == SHIFT) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                result <= res_nx;
                cnt    <= last ? cnt : cnt + 1'b1;
                // flags capture the completed word on the edge that enters DONE
                if (last) begin
                    zero <= res_nx == '0;
                    err  <= op_q == OP_RSVD;
                end
            end
        end
    end

`ifdef SERIAL_LOGIC_PARITY_EN
    logic acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= 1'b0;
            parity <= 1'b0;
        end else if (accept) begin
            acc <= 1'b0;
        end else if (state == SHIFT) begin
            acc <= acc ^ bit_z;
            if (last) parity <= acc ^ bit_z;
        end
    end
`endif
endmodule

// File: tb/tb_serial_logic_unit.sv
// tb_serial_logic_unit: randomized self-checking bench against a word-level reference model.
module tb_serial_logic_unit;
    localparam int W = 8;

    logic         clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready, zero, err;
    logic [2:0]   op;
    logic [W-1:0] a, b, result;
`ifdef SERIAL_LOGIC_PARITY_EN
    logic         parity;
`endif
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    serial_logic_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
`ifdef SERIAL_LOGIC_PARITY_EN
        .parity(parity),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .err(err)
    );

    function automatic logic [W-1:0] model(input int o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            0: return x & y;
            1: return x | y;
            2: return ~x;
            3: return ~(x & y);
            4: return ~(x | y);
            5: return x ^ y;
            6: return ~(x ^ y);
            default: return '0;
        endcase
    endfunction

    // Present one operation for a single cycle, then scramble the inputs.
    task automatic accept(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    endtask

    // lat counts edges with the acceptance edge as the first; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = 1;
        for (int i = 0; i < 4 * W; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) return;
        end
        lat = -1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (result !== '0) $display("FAIL reset_result got %h want 00", result); else passed++;
        total++; if ({zero, err} !== 2'b00) $display("FAIL reset_flags got %b want 00", {zero, err}); else passed++;
`ifdef SERIAL_LOGIC_PARITY_EN
        total++; if (parity !== 1'b0) $display("FAIL reset_parity got %b want 0", parity); else passed++;
`endif
    endtask

    task automatic test_and();
        int lat;
        accept(3'd0, 8'hF0, 8'h3C);
        wait_done(lat);
        total++; if (lat != W + 1) $display("FAIL and_latency got %0d want %0d", lat, W + 1); else passed++;
        total++; if (result !== 8'h30) $display("FAIL and_result got %h want 30", result); else passed++;
        total++; if ({zero, err} !== 2'b00) $display("FAIL and_flags got %b want 00", {zero, err}); else passed++;
        release_out();
        total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL and_release got %b want 01", {out_valid, in_ready}); else passed++;
    endtask

    task automatic test_all_ops();
        logic [W-1:0] table_exp [1:6];
        int lat;
        table_exp[1] = 8'hAF; table_exp[2] = 8'h5A; table_exp[3] = 8'hFA;
        table_exp[4] = 8'h50; table_exp[5] = 8'hAA; table_exp[6] = 8'h55;
        for (int o = 1; o <= 6; o++) begin
            accept(3'(o), 8'hA5, 8'h0F);
            wait_done(lat);
            total++; if (lat != W + 1 || result !== table_exp[o])
                $display("FAIL op%0d_result got %h lat %0d want %h lat %0d", o, result, lat, table_exp[o], W + 1);
            else passed++;
            release_out();
        end
    endtask

    task automatic test_stall();
        int lat;
        logic ok;
        accept(3'd5, 8'h3C, 8'h3C);
        wait_done(lat);
        total++; if (result !== 8'h00 || zero !== 1'b1) $display("FAIL stall_result got %h z%b want 00 z1", result, zero); else passed++;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; op = 3'd1; a = 8'hFF; b = 8'h01;
            @(posedge clk);
            @(negedge clk);
            ok &= out_valid === 1'b1 && in_ready === 1'b0 && result === 8'h00 && zero === 1'b1 && err === 1'b0;
        end
        in_valid = 1'b0;
        total++; if (!ok) $display("FAIL stall_hold got v%b r%b %h want v1 r0 00", out_valid, in_ready, result); else passed++;
        release_out();
        total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL stall_release got %b want 01", {out_valid, in_ready}); else passed++;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL stall_pulse_ignored got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_reserved();
        int lat;
        accept(3'd7, 8'hFF, 8'hFF);
        wait_done(lat);
        total++; if (lat != W + 1 || result !== 8'h00 || {zero, err} !== 2'b11)
            $display("FAIL rsvd got %h zf%b lat %0d want 00 zf11 lat %0d", result, {zero, err}, lat, W + 1);
        else passed++;
        release_out();
        accept(3'd1, 8'h12, 8'h40);
        wait_done(lat);
        total++; if (result !== 8'h52 || {zero, err} !== 2'b00) $display("FAIL rsvd_clear got %h zf%b want 52 zf00", result, {zero, err}); else passed++;
        release_out();
    endtask

    task automatic test_abort();
        logic seen;
        int lat;
        accept(3'($urandom_range(0, 6)), 8'hFF, 8'h0F);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if ({in_ready, out_valid} !== 2'b10 || result !== '0)
            $display("FAIL abort got r%b v%b %h want r1 v0 00", in_ready, out_valid, result);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (2 * W) begin
            @(negedge clk);
            seen |= out_valid;
        end
        total++; if (seen !== 1'b0) $display("FAIL abort_no_valid got %b want 0", seen); else passed++;
`ifdef SERIAL_LOGIC_PARITY_EN
        accept(3'd5, 8'h07, 8'h00);
        wait_done(lat);
        total++; if (parity !== 1'b1) $display("FAIL parity_07 got %b want 1", parity); else passed++;
        release_out();
`else
        lat = 0;
`endif
    endtask

    task automatic test_random();
        int lat, o;
        logic [W-1:0] x, y, exp;
        for (int n = 0; n < 24; n++) begin
            o = $urandom_range(0, 7);
            x = W'($urandom);
            y = W'($urandom);
            exp = model(o, x, y);
            accept(3'(o), x, y);
            wait_done(lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            total++; if (lat != W + 1 || result !== exp || zero !== (exp == '0) || err !== (o == 7))
                $display("FAIL rand op%0d a%h b%h got %h z%b e%b lat %0d want %h z%b e%b lat %0d",
                         o, x, y, result, zero, err, lat, exp, exp == '0, o == 7, W + 1);
            else passed++;
`ifdef SERIAL_LOGIC_PARITY_EN
            total++; if (parity !== ^exp) $display("FAIL rand_parity got %b want %b", parity, ^exp); else passed++;
`endif
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        int acc_at [$];
        logic [W-1:0] exp;
        exp = model(6, 8'h9C, 8'h35);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; op = 3'd6; a = 8'h9C; b = 8'h35;
        for (int i = 0; i < 2 * W + 4; i++) begin
            @(negedge clk);
            if (in_ready) acc_at.push_back(i);
            if (out_valid) begin
                total++; if (result !== exp) $display("FAIL b2b_result got %h want %h", result, exp); else passed++;
            end
            @(posedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if (acc_at.size() != 2 || acc_at[1] - acc_at[0] != W + 2)
            $display("FAIL b2b_spacing got %0d accepts want 2 spaced %0d", acc_at.size(), W + 2);
        else passed++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_and();
        test_all_ops();
        test_stall();
        test_reserved();
        test_abort();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/serial_logic_unit.md
Name: serial_logic_unit

Overview:
- Bit-serial, registered logic unit built on top of the team's single-bit gate primitives (AND/OR/NOT/NAND/NOR/XOR/XNOR).
- Accepts one pair of WIDTH-bit operands and an opcode through a valid/ready handshake.
- Evaluates one bit per clock, LSB first, through one shared 1-bit gate selector.
- Presents the full WIDTH-bit result plus flags through a downstream valid/ready handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range is WIDTH >= 2.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream operands and opcode are valid.
- in_ready  output  1  block can accept; high only in IDLE.
- op  input  3  opcode: 0 AND, 1 OR, 2 NOT(a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored for NOT.
- out_valid  output  1  result, zero and err are valid.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  computed result.
- zero  output  1  result == 0.
- err  output  1  reserved opcode (7) was accepted.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; result, operand shift registers, opcode register and counter are all 0.
  - out_valid = 0, zero = 0, err = 0, in_ready = 1 after reset deasserts.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at edge E0: latch a, b and op; clear result; counter = 0; go to SHIFT.
- SHIFT:
  - in_ready = 0.
  - Each edge computes bit = gate(op, a_sh[0], b_sh[0]).
  - result shifts right by 1 with bit inserted at result[WIDTH-1]; a_sh and b_sh shift right by 1; counter increments.
  - At the edge where counter == WIDTH-1, the last bit is inserted and the FSM goes to DONE.
  - After WIDTH edges, a[0]'s result bit sits in result[0].
- DONE:
  - out_valid = 1.
  - result, zero and err are held stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE; out_valid drops the next cycle.
  - result keeps its value until the next acceptance.
- Latency: out_valid rises WIDTH+1 edges after the acceptance edge E0.
- Throughput: one operation per WIDTH+2 cycles minimum, since in_ready is low in SHIFT and DONE.
- zero and err are registered when entering DONE.
- Reserved opcode 7: every result bit is 0, zero = 1, err = 1. Normal timing is kept; the operation is not dropped.
- in_valid while busy: ignored; upstream must hold its data until in_ready is high.
- Input changes on a, b, op after acceptance have no effect.
- Reset mid-SHIFT or mid-DONE aborts immediately: IDLE, outputs cleared, the partial result is lost, no out_valid.
- Counter compare uses CNT_W bits. Non-power-of-two WIDTH is legal; the counter never wraps past WIDTH-1.

Optional Feature:
- Macro: SERIAL_LOGIC_PARITY_EN.
- When defined:
  - Extra output port parity (1 bit).
  - Accumulated serially as XOR of every computed bit, cleared on acceptance.
  - Registered into the output on entering DONE; equals ^result.
  - Reset value 0.
- When undefined: no parity port and no parity flop; all other behaviour is identical.

Decomposition:
- Package serial_logic_pkg:
  - op_e enum (OP_AND=0 … OP_XNOR=6, OP_RSVD=7).
  - state_e enum (IDLE, SHIFT, DONE).
  - OP_W = 3.
- One sub-module, bit_gate: purely combinational 1-bit selector.
  - Inputs: op, x, y. Output: z.
  - Implements the seven gate functions; z = 0 for OP_RSVD.
- Instantiated once in serial_logic_unit.

Test Plan:
- Reset release, then idle → in_ready = 1, out_valid = 0, result = 0x00.
- WIDTH=8, op=0 (AND), a=0xF0, b=0x3C, out_ready=1 → out_valid rises 9 edges after acceptance, result = 0x30, zero = 0, err = 0.
- All opcodes 1–6 with a=0xA5, b=0x0F → OR 0xAF, NOT 0x5A, NAND 0xFA, NOR 0x50, XOR 0xAA, XNOR 0x55.
- op=5, a=0x3C, b=0x3C, out_ready held 0 for 5 cycles → result = 0x00, zero = 1, outputs stable while stalled; in_valid pulsed during the stall is ignored; IDLE one cycle after out_ready = 1.
- op=7, a=0xFF, b=0xFF → result = 0x00, zero = 1, err = 1; next op=1 clears err.
- Assert rst asynchronously at the 4th SHIFT cycle → immediate IDLE, out_valid never asserted, result = 0. With SERIAL_LOGIC_PARITY_EN, op=5, a=0x07, b=0x00 → parity = 1.
